// File: rtl/vend_if.sv
`default_nettype none
// ============================================================================
// Module  : vend_if
// Brief   : Coin/keypad, dispenser and change-ejector signals of vend_controller
// Revision: 1.0 - initial release
// ============================================================================
interface vend_if #(
  parameter int SEL_W    = 2,
  parameter int CREDIT_W = 8
);
  logic                coin5;
  logic                coin10;
  logic                sel_valid;
  logic [SEL_W-1:0]    sel_item;
  logic                cancel;
  logic                disp_req;
  logic [SEL_W-1:0]    disp_item;
  logic                disp_ack;
  logic                chg_req;
  logic                chg_ack;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                sel_denied;
  logic                busy;

  modport slave (
    input  coin5, coin10, sel_valid, sel_item, cancel, disp_ack, chg_ack,
    output disp_req, disp_item, chg_req, credit, coin_reject, sel_denied, busy
  );

  modport master (
    output coin5, coin10, sel_valid, sel_item, cancel, disp_ack, chg_ack,
    input  disp_req, disp_item, chg_req, credit, coin_reject, sel_denied, busy
  );
endinterface
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
// Module  : vend_controller
// Brief   : Multi-item vending sequencer: credit, selection, dispense, change
// Revision: 1.0 - initial release
// ============================================================================
module vend_controller #(
  parameter int                            NUM_ITEMS  = 4,
  parameter int                            CREDIT_W   = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = 32'h140F0A05,
  parameter int                            MAX_CREDIT = 50
) (
  input  logic  clk,
  input  logic  rst,
  vend_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_ITEMS);
  localparam logic [CREDIT_W:0] C_FIVE = (CREDIT_W+1)'(5);
  localparam logic [CREDIT_W:0] C_TEN  = (CREDIT_W+1)'(10);
  localparam logic [CREDIT_W:0] C_MAX  = (CREDIT_W+1)'(MAX_CREDIT);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SEL_W-1:0]    disp_item_q, disp_item_d;
  logic                disp_req_q, disp_req_d;
  logic                chg_req_q, chg_req_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_denied_q, sel_denied_d;
  logic                busy_q, busy_d;

  logic [CREDIT_W-1:0] price_tab [NUM_ITEMS];
  for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_price
    assign price_tab[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
  end

  logic [CREDIT_W:0]   coin_add;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_any;
  logic                coin_fits;
  logic                sel_in_range;
  logic [SEL_W-1:0]    sel_idx;
  logic [CREDIT_W-1:0] sel_price;

  assign coin_add     = (bus.coin5 ? C_FIVE : '0) + (bus.coin10 ? C_TEN : '0);
  assign coin_any     = bus.coin5 | bus.coin10;
  assign coin_sum     = {1'b0, credit_q} + coin_add;
  assign coin_fits    = (coin_sum <= C_MAX);
  assign sel_in_range = ({1'b0, bus.sel_item} < (SEL_W+1)'(NUM_ITEMS));
  assign sel_idx      = sel_in_range ? bus.sel_item : '0;
  assign sel_price    = price_tab[sel_idx];

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    disp_item_d   = disp_item_q;
    coin_reject_d = 1'b0;
    sel_denied_d  = 1'b0;
    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        if (coin_any) begin
          if (coin_fits) credit_d = coin_sum[CREDIT_W-1:0];
          else           coin_reject_d = 1'b1;
        end
        state_d = (credit_d != '0) ? S_COLLECT : S_IDLE;
        // Cancel only acts with credit present; otherwise selection is evaluated on pre-coin credit
        if (bus.cancel && state_q == S_COLLECT) begin
          state_d = S_CHANGE;
        end else if (bus.sel_valid) begin
          if (!sel_in_range || credit_q < sel_price) begin
            sel_denied_d = 1'b1;
          end else begin
            disp_item_d = sel_idx;
            credit_d    = credit_d - sel_price;
            state_d     = S_VEND;
          end
        end
      end
      S_VEND: begin
        coin_reject_d = coin_any;
        if (bus.disp_ack) state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        coin_reject_d = coin_any;
        if (bus.chg_ack) begin
          credit_d = credit_q - C_FIVE[CREDIT_W-1:0];
          if (credit_q == C_FIVE[CREDIT_W-1:0]) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    disp_req_d = (state_d == S_VEND);
    chg_req_d  = (state_d == S_CHANGE);
    busy_d     = disp_req_d | chg_req_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      disp_item_q   <= '0;
      disp_req_q    <= 1'b0;
      chg_req_q     <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_denied_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      disp_item_q   <= disp_item_d;
      disp_req_q    <= disp_req_d;
      chg_req_q     <= chg_req_d;
      coin_reject_q <= coin_reject_d;
      sel_denied_q  <= sel_denied_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.credit      = credit_q;
  assign bus.disp_item   = disp_item_q;
  assign bus.disp_req    = disp_req_q;
  assign bus.chg_req     = chg_req_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.sel_denied  = sel_denied_q;
  assign bus.busy        = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_vend_controller
// Brief   : Directed and random stimulus against a behavioural vending model
// Revision: 1.0 - initial release
// ============================================================================
module tb_vend_controller;
  localparam int NUM_ITEMS  = 4;
  localparam int MAX_CREDIT = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vend_if #(.SEL_W(2), .CREDIT_W(8)) vif ();
  vend_if #(.SEL_W(2), .CREDIT_W(8)) vif3 ();

  vend_controller #(.NUM_ITEMS(4), .CREDIT_W(8), .PRICES(32'h140F0A05), .MAX_CREDIT(50))
    dut (.clk(clk), .rst(rst), .bus(vif));

  vend_controller #(.NUM_ITEMS(3), .CREDIT_W(8), .PRICES(24'h0F0A05), .MAX_CREDIT(50))
    dut3 (.clk(clk), .rst(rst), .bus(vif3));

  int errors = 0;
  int checks = 0;
  int price [NUM_ITEMS] = '{5, 10, 15, 20};

  // Reference: credit as a plain integer plus "dispensing"/"paying out" flags
  int m_credit;
  int m_item;
  bit m_vend, m_chg, m_rej, m_den;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_item = 0;
    m_vend = 0; m_chg = 0; m_rej = 0; m_den = 0;
  endtask

  task automatic model_step(input bit c5, input bit c10, input bit sv, input int si,
                            input bit cn, input bit da, input bit ca);
    int add = (c5 ? 5 : 0) + (c10 ? 10 : 0);
    int pre = m_credit;
    m_rej = 0; m_den = 0;
    if (m_vend) begin
      m_rej = (add > 0);
      if (da) begin m_vend = 0; m_chg = (m_credit > 0); end
    end else if (m_chg) begin
      m_rej = (add > 0);
      if (ca) begin m_credit -= 5; if (m_credit == 0) m_chg = 0; end
    end else begin
      if (add > 0) begin
        if (pre + add <= MAX_CREDIT) m_credit += add;
        else m_rej = 1;
      end
      if (cn && pre > 0) m_chg = 1;
      else if (sv) begin
        if (si >= NUM_ITEMS || pre < price[si]) m_den = 1;
        else begin m_item = si; m_credit -= price[si]; m_vend = 1; end
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("credit",      32'(vif.credit),      32'(m_credit));
    check_eq("disp_req",    32'(vif.disp_req),    32'(m_vend));
    check_eq("disp_item",   32'(vif.disp_item),   32'(m_item));
    check_eq("chg_req",     32'(vif.chg_req),     32'(m_chg));
    check_eq("coin_reject", 32'(vif.coin_reject), 32'(m_rej));
    check_eq("sel_denied",  32'(vif.sel_denied),  32'(m_den));
    check_eq("busy",        32'(vif.busy),        32'(m_vend | m_chg));
  endtask

  task automatic cycle(input bit c5, input bit c10, input bit sv, input int si,
                       input bit cn, input bit da, input bit ca);
    @(negedge clk);
    vif.coin5 = c5; vif.coin10 = c10; vif.sel_valid = sv; vif.sel_item = 2'(si);
    vif.cancel = cn; vif.disp_ack = da; vif.chg_ack = ca;
    @(posedge clk);
    model_step(c5, c10, sv, si, cn, da, ca);
    #1 check_outputs();
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (!vif.busy && vif.credit == 0) break;
      cycle(0, 0, 0, 0, 1, 1, 1);
    end
    check_eq("drain_idle", {vif.busy, 23'd0, vif.credit}, 32'd0);
  endtask

  task automatic count_change(input string tag, input int expected);
    int n = 0;
    for (int i = 0; i < 12; i++) begin
      if (!vif.chg_req) break;
      cycle(0, 0, 0, 0, 0, 0, 1);
      n++;
    end
    check_eq(tag, 32'(n), 32'(expected));
  endtask

  task automatic check_reset_now(input string tag);
    check_eq(tag, {vif.credit, vif.disp_req, vif.chg_req, vif.coin_reject,
                   vif.sel_denied, vif.busy, vif.disp_item}, 32'd0);
  endtask

  initial begin
    {vif.coin5, vif.coin10, vif.sel_valid, vif.cancel, vif.disp_ack, vif.chg_ack} = '0;
    vif.sel_item = '0;
    {vif3.coin5, vif3.coin10, vif3.sel_valid, vif3.cancel, vif3.disp_ack, vif3.chg_ack} = '0;
    vif3.sel_item = '0;
    model_reset();
    @(negedge clk);
    check_reset_now("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // T1: exact payment, no change
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 2, 0, 0, 0);
    check_eq("t1_disp", {vif.disp_req, vif.disp_item}, {1'b1, 2'd2});
    cycle(0, 0, 0, 0, 0, 1, 0);
    check_eq("t1_done", {vif.busy, vif.chg_req, 22'd0, vif.credit}, 32'd0);

    // T2: overpay by 10, two change coins
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0, 0);
    check_eq("t2_credit_vend", 32'(vif.credit), 32'd10);
    cycle(0, 0, 0, 0, 0, 1, 0);
    count_change("t2_handshakes", 2);
    check_eq("t2_final_credit", 32'(vif.credit), 32'd0);

    // T3: insufficient credit
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 3, 0, 0, 0);
    check_eq("t3_denied", {vif.sel_denied, vif.busy, vif.credit}, {1'b1, 1'b0, 8'd5});
    drain();

    // T4: credit ceiling
    repeat (4) cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    check_eq("t4_reject45", {vif.coin_reject, vif.credit}, {1'b1, 8'd45});
    cycle(1, 0, 0, 0, 0, 0, 0);
    check_eq("t4_fill50", 32'(vif.credit), 32'd50);
    drain();
    repeat (4) cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    check_eq("t4_both_refused", {vif.coin_reject, vif.credit}, {1'b1, 8'd40});
    drain();

    // T5: cancel beats selection; coin during payout refused
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 1, 0, 0);
    check_eq("t5_change", {vif.chg_req, vif.disp_req}, {1'b1, 1'b0});
    cycle(1, 0, 0, 0, 0, 0, 0);
    check_eq("t5_coin_in_change", {vif.coin_reject, vif.credit}, {1'b1, 8'd15});
    count_change("t5_handshakes", 3);

    // Three-item build: index 3 is out of range even with ample credit
    @(negedge clk); vif3.coin10 = 1'b1;
    @(negedge clk); vif3.coin10 = 1'b0;
    @(negedge clk); vif3.coin10 = 1'b1;
    @(negedge clk); vif3.coin10 = 1'b0; vif3.sel_valid = 1'b1; vif3.sel_item = 2'd3;
    @(negedge clk); vif3.sel_valid = 1'b0;
    check_eq("t3_num3_denied", {vif3.sel_denied, vif3.busy, vif3.credit}, {1'b1, 1'b0, 8'd20});
    idle_cycle();

    // T6: asynchronous reset mid-VEND and mid-CHANGE
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    check_eq("t6_in_vend", 32'(vif.disp_req), 32'd1);
    @(negedge clk); rst = 1'b1;
    #1 check_reset_now("t6_rst_vend");
    model_reset();
    @(negedge clk); rst = 1'b0;
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    check_eq("t6_in_change", 32'(vif.chg_req), 32'd1);
    @(negedge clk); rst = 1'b1;
    #1 check_reset_now("t6_rst_change");
    model_reset();
    @(negedge clk); rst = 1'b0;
    cycle(0, 0, 0, 0, 0, 0, 1);
    check_eq("t6_ack_ignored", {vif.busy, vif.credit}, 9'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 6) == 0, ($urandom % 6) == 0, ($urandom % 4) == 0,
            int'($urandom % 4), ($urandom % 15) == 0,
            ($urandom % 3) == 0, ($urandom % 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
